acq_mem_ctrl: RTL and testbench
===============================

// Module: acq_mem_ctrl
// PURPOSE
//  Sequences one acquisition search over the sample memory bank: waits for a full capture
//  window in WRITING mode, switches the bank to PLAYBACK, replays the window NUM_PASSES times
//  (one Doppler bin per pass) and returns the bank to WRITING. Sits between the search
//  top level (start/abort/done) and the bank's mode/ready/frame strobes; gates the correlator accumulators.
// PARAMETERS
//  NUM_PASSES    21      playback passes (Doppler bins) per search, >=1
//  PASS_W        5       width of pass_idx; 2**PASS_W >= NUM_PASSES
//  DOPP_W        16      width of signed dopp_offset
//  DOPP_START    -5000   dopp_offset for pass 0 (signed)
//  DOPP_STEP     500     dopp_offset increment per pass (signed)
//  FILL_TIMEOUT  65535   max cycles in FILL before timeout; TO_W 16 = watchdog width
// PORTS
//  clk              in   1       system clock
//  reset            in   1       synchronous, active-high
//  start            in   1       pulse: begin search (ignored unless IDLE)
//  abort            in   1       level/pulse: cancel search, highest priority
//  mem_ready        in   1       bank ready flag
//  mem_frame_start  in   1       bank first playback sample of window
//  mem_frame_end    in   1       bank last playback sample of window
//  mem_sample_valid in   1       bank playback sample valid
//  mem_mode         out  1       bank mode, encodings MODE_WRITING/MODE_PLAYBACK
//  pass_idx         out  PASS_W  current pass, 0..NUM_PASSES-1
//  dopp_offset      out  DOPP_W  signed Doppler offset of current pass
//  pass_start       out  1       1-cycle pulse, pass begins
//  pass_end         out  1       1-cycle pulse, pass finished
//  acc_enable       out  1       combinational: accumulate current bank sample
//  busy / done / timeout  out 1 each  state!=IDLE / search complete pulse / fill watchdog pulse
// BEHAVIOUR
//  - Reset: state IDLE, mem_mode=MODE_WRITING, pass_idx=0, dopp_offset=DOPP_START, all pulses 0.
//  - All outputs registered except acc_enable. abort beats every other event in same cycle.
//  - IDLE: mem_mode WRITING (bank keeps capturing). start: pass_idx<=0, dopp_offset<=DOPP_START;
//    if mem_ready=1 -> ARM else -> FILL (watchdog cleared).
//  - FILL: watchdog++ each cycle. mem_ready=1 -> ARM. Watchdog==FILL_TIMEOUT-1 without ready ->
//    timeout pulse next cycle, -> IDLE. Ready and timeout same cycle: ready wins.
//  - ARM: mem_mode<=MODE_PLAYBACK on entry (visible cycle after transition). Wait for
//    mem_frame_start && mem_sample_valid -> PLAY, pass_start pulse next cycle. The bank's
//    mode-change cycle (sample_valid=0) is ignored by construction.
//  - PLAY: mem_frame_start && valid -> pass_start pulse next cycle. mem_frame_end && valid ->
//    pass_end pulse next cycle; if pass_idx==NUM_PASSES-1 -> DONE, else pass_idx+1,
//    dopp_offset+=DOPP_STEP (DOPP_W modulo wrap, no saturation). Next window follows
//    back-to-back; no gap state.
//  - DONE: done pulse 1 cycle, mem_mode<=MODE_WRITING, -> IDLE. pass_idx/dopp_offset hold last
//    value until next start.
//  - acc_enable = mem_sample_valid && (state==PLAY || (state==ARM && mem_frame_start)).
//    Exactly (window length) enables per pass; zero outside ARM/PLAY.
//  - abort in FILL/ARM/PLAY/DONE: -> IDLE, mem_mode<=MODE_WRITING, no done/pass_end; an
//    in-flight pass is discarded. abort in IDLE with start: stay IDLE.
//  - start while busy: ignored. reset mid-search: immediate reset state, no pulses.
//  - NUM_PASSES=1: first frame_end goes directly to DONE.
// STRUCTURE
//  - acq_ctrl.vh: state encodings (IDLE,FILL,ARM,PLAY,DONE), default widths; MODE_* taken
//    from mem_bank.vh, not redefined.
//  - One sub-module: fill_watchdog (clear/enable/terminal-count counter, TO_W wide).
//  - Main FSM + pass/Doppler counters in acq_mem_ctrl; pulses are registered one-shots.
// TESTING
//  - Reset held 3 cycles mid-PLAY -> mem_mode=WRITING, busy=0, pass_idx=0, dopp_offset=-5000.
//  - start with mem_ready=1, NUM_PASSES=3, bank model 16-sample window -> 3 pass_start,
//    3 pass_end, 48 acc_enable cycles, dopp_offset -5000/-4500/-4000, done 1 cycle.
//  - start with mem_ready=0, ready rises after 100 cycles -> FILL then ARM; no timeout.
//  - FILL_TIMEOUT=50, ready never rises -> timeout pulses exactly cycle 50, state IDLE, done=0.
//  - abort in pass 1 at sample 7 -> IDLE next cycle, mem_mode=WRITING, no pass_end, no done.
//  - start pulsed during PLAY; start+abort same cycle in IDLE -> both ignored, busy unaffected.

Source files
------------

// File: rtl/acq_mem_ctrl_pkg.sv
// Shared types and constants for the acquisition memory controller.
// Bank mode encodings mirror the sample memory bank's own definitions.
package acq_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ARM  = 3'd2,
        ST_PLAY = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic MODE_WRITING  = 1'b0;
    localparam logic MODE_PLAYBACK = 1'b1;

    localparam int unsigned DEF_PASS_W = 5;
    localparam int unsigned DEF_DOPP_W = 16;
    localparam int unsigned DEF_TO_W   = 16;

endpackage

// File: rtl/acq_mem_ctrl_fill_watchdog.sv
// Fill watchdog: counts cycles spent waiting for a full capture window and
// flags the terminal count one cycle before the limit is reached.
module acq_mem_ctrl_fill_watchdog #(
    parameter int unsigned TO_W  = 16,
    parameter int unsigned LIMIT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

    assign terminal_c = (count == TO_W'(LIMIT - 1));

endmodule

// File: rtl/acq_mem_ctrl.sv
// Acquisition search sequencer: fills a capture window, replays it once per
// Doppler bin in playback mode, and returns the bank to writing mode.
module acq_mem_ctrl
    import acq_mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PASSES   = 21,
    parameter int unsigned PASS_W       = DEF_PASS_W,
    parameter int unsigned DOPP_W       = DEF_DOPP_W,
    parameter int          DOPP_START   = -5000,
    parameter int          DOPP_STEP    = 500,
    parameter int unsigned FILL_TIMEOUT = 65535,
    parameter int unsigned TO_W         = DEF_TO_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mem_ready,
    input  logic              mem_frame_start,
    input  logic              mem_frame_end,
    input  logic              mem_sample_valid,
    output logic              mem_mode,
    output logic [PASS_W-1:0] pass_idx,
    output logic [DOPP_W-1:0] dopp_offset,
    output logic              pass_start,
    output logic              pass_end,
    output logic              acc_enable,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    state_t state;
    logic   wd_clear_c;
    logic   wd_enable_c;
    logic   fill_expired_c;
    logic   frame_first_c;
    logic   frame_last_c;
    logic   last_pass_c;

    assign wd_clear_c    = (state != ST_FILL);
    assign wd_enable_c   = (state == ST_FILL);
    assign frame_first_c = mem_frame_start && mem_sample_valid;
    assign frame_last_c  = mem_frame_end && mem_sample_valid;
    assign last_pass_c   = (pass_idx == PASS_W'(NUM_PASSES - 1));

    // The ARM cycle that sees the first sample already belongs to the window.
    assign acc_enable = mem_sample_valid &&
                        ((state == ST_PLAY) || ((state == ST_ARM) && mem_frame_start));

    acq_mem_ctrl_fill_watchdog #(
        .TO_W  (TO_W),
        .LIMIT (FILL_TIMEOUT)
    ) u_fill_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clear      (wd_clear_c),
        .enable     (wd_enable_c),
        .terminal_c (fill_expired_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_mode    <= MODE_WRITING;
            pass_idx    <= '0;
            dopp_offset <= DOPP_W'(DOPP_START);
            pass_start  <= 1'b0;
            pass_end    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            pass_start <= 1'b0;
            pass_end   <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;

            if (abort) begin
                // Discards any in-flight pass without reporting it.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                mem_mode <= MODE_WRITING;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pass_idx    <= '0;
                            dopp_offset <= DOPP_W'(DOPP_START);
                            busy        <= 1'b1;
                            if (mem_ready) begin
                                state    <= ST_ARM;
                                mem_mode <= MODE_PLAYBACK;
                            end else begin
                                state <= ST_FILL;
                            end
                        end
                    end
                    ST_FILL: begin
                        if (mem_ready) begin
                            state    <= ST_ARM;
                            mem_mode <= MODE_PLAYBACK;
                        end else if (fill_expired_c) begin
                            timeout <= 1'b1;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (frame_first_c) begin
                            pass_start <= 1'b1;
                            state      <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (frame_first_c) begin
                            pass_start <= 1'b1;
                        end
                        if (frame_last_c) begin
                            pass_end <= 1'b1;
                            if (last_pass_c) begin
                                state <= ST_DONE;
                            end else begin
                                pass_idx    <= pass_idx + PASS_W'(1);
                                dopp_offset <= dopp_offset + DOPP_W'(DOPP_STEP);
                            end
                        end
                    end
                    ST_DONE: begin
                        done     <= 1'b1;
                        mem_mode <= MODE_WRITING;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        mem_mode <= MODE_WRITING;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_mem_ctrl.sv
// Scoreboard bench for acq_mem_ctrl: stimulus queues expected pulses, a
// negedge monitor pops and compares them against the DUT's pulse outputs.
module tb_acq_mem_ctrl;

    localparam int NP  = 3;
    localparam int FT  = 50;
    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        reset, start, abort, mem_ready;
    logic        mem_frame_start, mem_frame_end, mem_sample_valid;
    logic        mem_mode;
    logic [4:0]  pass_idx;
    logic [15:0] dopp_offset;
    logic        pass_start, pass_end, acc_enable, busy, done, timeout;

    typedef enum int {EV_PS, EV_PE, EV_DONE, EV_TO} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
        int       dopp;
    } ev_t;

    ev_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  acc_cnt = 0;

    always #5 clk = ~clk;

    acq_mem_ctrl #(
        .NUM_PASSES   (NP),
        .FILL_TIMEOUT (FT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .mem_ready        (mem_ready),
        .mem_frame_start  (mem_frame_start),
        .mem_frame_end    (mem_frame_end),
        .mem_sample_valid (mem_sample_valid),
        .mem_mode         (mem_mode),
        .pass_idx         (pass_idx),
        .dopp_offset      (dopp_offset),
        .pass_start       (pass_start),
        .pass_end         (pass_end),
        .acc_enable       (acc_enable),
        .busy             (busy),
        .done             (done),
        .timeout          (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dopp_of(input int idx);
        return -5000 + 500 * idx;
    endfunction

    task automatic push_ev(input ev_kind_t k, input int idx);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        e.dopp = dopp_of(idx);
        exp_q.push_back(e);
    endtask

    // Pass p starts with idx p; its end is seen after the counters advance.
    task automatic push_pass(input int p, input bit with_end);
        int after;
        after = (p == NP - 1) ? p : p + 1;
        push_ev(EV_PS, p);
        if (with_end) push_ev(EV_PE, after);
    endtask

    task automatic mon(input ev_kind_t k);
        ev_t e;
        int  di;
        di = int'($signed(dopp_offset));
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d idx %0d dopp %0d, expected none",
                     k, pass_idx, di);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.idx != int'(pass_idx) || e.dopp != di) begin
            errors++;
            $display("FAIL pulse: got kind %0d idx %0d dopp %0d, expected kind %0d idx %0d dopp %0d",
                     k, pass_idx, di, e.kind, e.idx, e.dopp);
        end
    endtask

    always @(negedge clk) begin
        if (acc_enable === 1'b1) acc_cnt++;
        if (pass_start === 1'b1) mon(EV_PS);
        if (pass_end === 1'b1)   mon(EV_PE);
        if (done === 1'b1)       mon(EV_DONE);
        if (timeout === 1'b1)    mon(EV_TO);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bank_idle();
        mem_sample_valid = 1'b0;
        mem_frame_start  = 1'b0;
        mem_frame_end    = 1'b0;
    endtask

    task automatic do_start(input logic rdy);
        mem_ready = rdy;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bank model: one mode-change cycle, then back-to-back windows. Optionally
    // cuts the run with abort or a 3-cycle reset at (cut_win, cut_smp).
    task automatic play(input int n_win, input int cut_win, input int cut_smp,
                        input bit cut_rst, input int st_win);
        bank_idle();
        tick();
        for (int w = 0; w < n_win; w++) begin
            for (int i = 0; i < WIN; i++) begin
                mem_sample_valid = 1'b1;
                mem_frame_start  = (i == 0);
                mem_frame_end    = (i == WIN - 1);
                start            = (w == st_win && i == 3);
                if (w == cut_win && i == cut_smp) begin
                    if (cut_rst) reset = 1'b1;
                    else abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                    bank_idle();
                    if (cut_rst) begin
                        tick();
                        tick();
                        reset = 1'b0;
                    end
                    return;
                end
                tick();
            end
        end
        start = 1'b0;
        bank_idle();
    endtask

    initial begin
        int first_to;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mem_ready = 1'b0;
        bank_idle();

        // Power-on reset
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_mem_mode", int'(mem_mode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pass_idx", int'(pass_idx), 0);
        check("rst_dopp", int'($signed(dopp_offset)), -5000);
        check("rst_pulses", int'({pass_start, pass_end, done, timeout}), 0);

        // Full search, bank ready, with a stray start in pass 1
        for (int p = 0; p < NP; p++) push_pass(p, 1'b1);
        push_ev(EV_DONE, NP - 1);
        do_start(1'b1);
        check("arm_mem_mode", int'(mem_mode), 1);
        check("arm_busy", int'(busy), 1);
        acc_cnt = 0;
        play(NP, -1, 0, 1'b0, 1);
        check("play_busy_mid_done", int'(busy), 1);
        tick();
        tick();
        check("full_acc_cnt", acc_cnt, NP * WIN);
        check("full_busy", int'(busy), 0);
        check("full_mem_mode", int'(mem_mode), 0);
        check("full_hold_idx", int'(pass_idx), NP - 1);
        check("full_hold_dopp", int'($signed(dopp_offset)), -4000);
        check("full_queue_empty", exp_q.size(), 0);

        // Abort in pass 1 at sample 7
        push_pass(0, 1'b1);
        push_pass(1, 1'b0);
        do_start(1'b1);
        acc_cnt = 0;
        play(NP, 1, 7, 1'b0, -1);
        check("abort_busy", int'(busy), 0);
        check("abort_mem_mode", int'(mem_mode), 0);
        repeat (4) tick();
        check("abort_acc_cnt", acc_cnt, WIN + 8);
        check("abort_queue_empty", exp_q.size(), 0);

        // Fill then ready: no timeout, proceeds to ARM
        do_start(1'b0);
        check("fill_busy", int'(busy), 1);
        check("fill_mem_mode", int'(mem_mode), 0);
        repeat (30) tick();
        check("fill_still_busy", int'(busy), 1);
        mem_ready = 1'b1;
        tick();
        check("fill_arm_mem_mode", int'(mem_mode), 1);
        push_pass(0, 1'b0);
        acc_cnt = 0;
        play(NP, 0, 2, 1'b0, -1);
        tick();
        check("fill_acc_cnt", acc_cnt, 3);
        check("fill_queue_empty", exp_q.size(), 0);

        // Fill watchdog expiry
        push_ev(EV_TO, 0);
        do_start(1'b0);
        first_to = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (timeout === 1'b1 && first_to == 0) first_to = k;
        end
        check("timeout_cycle", first_to, FT);
        check("timeout_busy", int'(busy), 0);
        check("timeout_mem_mode", int'(mem_mode), 0);
        check("timeout_queue_empty", exp_q.size(), 0);

        // start and abort together in IDLE
        mem_ready = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("st_ab_busy", int'(busy), 0);
        tick();
        check("st_ab_busy2", int'(busy), 0);
        check("st_ab_mem_mode", int'(mem_mode), 0);

        // Reset held 3 cycles mid-PLAY (pass 1)
        push_pass(0, 1'b1);
        push_pass(1, 1'b0);
        do_start(1'b1);
        play(NP, 1, 5, 1'b1, -1);
        tick();
        check("midrst_mem_mode", int'(mem_mode), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pass_idx", int'(pass_idx), 0);
        check("midrst_dopp", int'($signed(dopp_offset)), -5000);
        repeat (3) tick();
        check("midrst_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
